// File: rtl/multi_cycle_fsm_pkg.sv
// rtl/multi_cycle_fsm_pkg.sv - phase encodings, PC source codes, opcodes and legality check
package multi_cycle_fsm_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;

    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_R: ok = (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
                       (funct == FUNCT_AND) || (funct == FUNCT_OR);
            OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multi_cycle_fsm.sv
// rtl/multi_cycle_fsm.sv - instruction-phase sequencer for the multi-period MIPS core
module multi_cycle_fsm
    import multi_cycle_fsm_pkg::*;
#(
    parameter int STATE_LEN = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic [STATE_LEN-1:0] state,
    output logic                 mem_req,
    output logic                 mem_write_en,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write_en,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired
);

    // Plain vector so the unused codes 5 and 6 are representable and recoverable.
    logic [2:0] cur;
    logic [2:0] nxt;
    logic       retire;
    logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic [1:0] pc_src_c;

    always_comb begin
        nxt         = cur;
        retire      = 1'b0;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = PC_SRC_SEQ;
        reg_write_c = 1'b0;
        case (cur)
            S_IF: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    nxt        = S_ID;
                end
            end
            S_ID: begin
                if (opcode == OP_J) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = PC_SRC_JUMP;
                    retire     = 1'b1;
                    nxt        = S_IF;
                end else if (is_legal(opcode, funct)) begin
                    nxt = S_EX;
                end else begin
                    nxt = S_ERR;
                end
            end
            S_EX: begin
                if (opcode == OP_BEQ) begin
                    pc_write_c = zero;
                    pc_src_c   = zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
                    retire     = 1'b1;
                    nxt        = S_IF;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c   = 1'b1;
                mem_write_c = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire = 1'b1;
                        nxt    = S_IF;
                    end else begin
                        nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                nxt         = S_IF;
            end
            S_ERR: nxt = S_ERR;
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur     <= S_IF;
            retired <= '0;
            halted  <= 1'b0;
        end else begin
            cur <= nxt;
            if (retire) retired <= retired + CNT_W'(1);
            if (nxt == S_ERR && cur != S_ERR) halted <= 1'b1;
        end
    end

    // Reset must silence the memory port immediately, not one edge later.
    assign mem_req      = rst_n & mem_req_c;
    assign mem_write_en = rst_n & mem_write_c;
    assign ir_write     = rst_n & ir_write_c;
    assign pc_write     = rst_n & pc_write_c;
    assign pc_src       = rst_n ? pc_src_c : PC_SRC_SEQ;
    assign reg_write_en = rst_n & reg_write_c;
    assign state        = STATE_LEN'(cur);

endmodule
